// File: rtl/scan_pkg.sv
// scan_pkg: shared FSM state type and MISR constant for scan_chain_ctrl.
// MISR_POLY is consumed only when SCAN_CHAIN_MISR_EN is defined.
package scan_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CAPTURE,
        UNLOAD,
        DONE
    } scan_state_e;

    localparam logic [7:0] MISR_POLY = 8'h1D;

endpackage

// File: rtl/scan_misr.sv
// scan_misr: Galois-form signature register over the unloaded responses.
// Instantiated by scan_chain_ctrl only when SCAN_CHAIN_MISR_EN is defined.
module scan_misr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             en,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] sig
);
    import scan_pkg::*;

    localparam logic [WIDTH-1:0] POLY = WIDTH'(MISR_POLY);

    logic [WIDTH-1:0] fb;

    // polynomial feedback when the MSB shifts out
    always_comb begin
        fb = sig[WIDTH-1] ? POLY : '0;
    end

    // seed 0 at test start, fold one word per enabled cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= '0;
        end else if (clear) begin
            sig <= '0;
        end else if (en) begin
            sig <= {sig[WIDTH-2:0], 1'b0} ^ fb ^ data;
        end
    end

endmodule

// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl: load / capture / unload sequencer for one scan chain.
// Optional MISR signature enabled by defining SCAN_CHAIN_MISR_EN.
module scan_chain_ctrl #(
    parameter int WIDTH     = 8,
    parameter int CHAIN_LEN = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             pat_valid,
    input  logic [WIDTH-1:0] pat_data,
    output logic             pat_ready,
    output logic             scan_se,
    output logic [WIDTH-1:0] scan_si,
    input  logic [WIDTH-1:0] scan_so,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_data,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] signature
);
    import scan_pkg::*;

    localparam int CNT_W = $clog2(CHAIN_LEN);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    scan_state_e      state;
    logic [CNT_W-1:0] cnt;

    // sequencer: state, per-state counter and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
        end else begin
            done       <= 1'b0;
            err        <= 1'b0;
            resp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                        cnt   <= '0;
                    end
                end
                LOAD: begin
                    if (!pat_valid) begin
                        state <= IDLE;
                        cnt   <= '0;
                        err   <= 1'b1;
                    end else if (cnt == LAST) begin
                        state <= CAPTURE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                CAPTURE: begin
                    state <= UNLOAD;
                    cnt   <= '0;
                end
                UNLOAD: begin
                    resp_valid <= 1'b1;
                    resp_data  <= scan_so;
                    if (cnt == LAST) begin
                        state <= DONE;
                        cnt   <= '0;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // scan controls decode straight from the state
    always_comb begin
        scan_se   = 1'b0;
        scan_si   = '0;
        pat_ready = 1'b0;
        unique case (state)
            LOAD: begin
                scan_se   = 1'b1;
                scan_si   = pat_data;
                pat_ready = 1'b1;
            end
            UNLOAD: begin
                scan_se = 1'b1;
            end
            default: begin
                scan_se = 1'b0;
            end
        endcase
    end

    assign busy = (state != IDLE);

`ifdef SCAN_CHAIN_MISR_EN
    logic misr_clear;
    logic misr_en;

    // scan_so is folded on the same edge that registers resp_data,
    // so the signature already covers the last word while done is high
    assign misr_clear = (state == IDLE) && start;
    assign misr_en    = (state == UNLOAD);

    scan_misr #(
        .WIDTH (WIDTH)
    ) u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (misr_clear),
        .en    (misr_en),
        .data  (scan_so),
        .sig   (signature)
    );
`else
    assign signature = '0;
`endif

endmodule
